xoodyak_build: RTL and testbench
================================

XOODYAK_BUILD -- requirements
Module: xoodyak_build

Interface
REQ-001 eph1  input  1  single clock; all flops rising-edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  command strobe; sampled on eph1 rising edge only while idle.
REQ-004 input_data  input  352  command data, Rkin = 44 bytes; byte k = input_data[351-8k -: 8]; key/nonce occupy bytes 0..15.
REQ-005 opmode  input  6  [2:0] op: 0 idle, 1 initialize, 2 nonce, 3 assoc-data absorb, 4 encrypt, 5 decrypt, 6 squeeze, 7 ratchet; [5] continue (1 = later block of the same operation); [4:3] ignored.
REQ-006 textout  output  192  Rkout = 24 bytes of cipher/plain/squeeze output; byte k = textout[191-8k -: 8].
REQ-007 finished  output  1  one-cycle pulse: command complete, textout valid.

Function
REQ-008 State S is 384 bits; byte k = S[383-8k -: 8]; lane j = bytes 4j..4j+3, little-endian; plane y = j/4, x = j%4.
REQ-009 Xoodoo round, 12 rounds, one round per clock:
- theta: P = A0^A1^A2; Ay[x] ^= rotl(P[x-1],5) ^ rotl(P[x-1],14).
- rho-west: A1[x] = A1[x-1]; A2[x] = rotl(A2[x],11).
- iota: A0[0] ^= C.
- chi: Ay ^= ~A(y+1) & A(y+2).
- rho-east: A1[x] = rotl(A1[x],1); A2[x] = rotl(A2[x-2],8).
REQ-010 Round constants C, in order: 058,038,3C0,0D0,120,014,060,02C,380,0F0,1A0,012 (hex).
REQ-011 Up(Cu): S byte 47 ^= Cu; run 12 rounds; Y = bytes 0..23; phase = UP.
REQ-012 Down(X,n,Cd): bytes 0..n-1 ^= X; byte n ^= 0x01; byte 47 ^= Cd; phase = DOWN.
REQ-013 Initialize: S = 0; then Down(key||0x00, 17, 0x02); no permutation.
REQ-014 Nonce: Up(0x00) if phase == DOWN; then Down(bytes 0..15, 16, 0x03).
REQ-015 Assoc: Up(0x00) if phase == DOWN; then Down(44 bytes, 44, Cd), Cd = 0x03 if continue = 0 else 0x00.
REQ-016 Encrypt: Up(Cu), Cu = 0x80 if continue = 0 else 0x00; textout = P ^ Y using P = bytes 0..23; Down(P, 24, 0x00).
REQ-017 Decrypt: same Up; textout = C ^ Y; Down(textout, 24, 0x00).
REQ-018 Squeeze: Up(0x40) if continue = 0 else Up(0x00); textout = Y; Down(empty, 0, 0x00).
REQ-019 Ratchet: Up(0x10); Down(Y bytes 0..15, 16, 0x00); textout unchanged.
REQ-020 Latency: initialize, and nonce/assoc when phase == UP, assert finished 1 cycle after the start edge. All other commands assert finished 13 cycles after (1 capture + 12 rounds).
REQ-021 opmode and input_data are registered on the accepted start edge; later changes to either input do not affect the command.
REQ-022 start while busy is ignored, with no queueing. start with op 0 does nothing and produces no finished pulse.
REQ-023 textout holds its value until the next encrypt, decrypt or squeeze completes.
REQ-024 A busy round counter 0..11 runs during Up; returning to idle and pulsing finished happen in the same edge-completion cycle.

Reset
REQ-025 reset low clears S, phase (= UP), round counter, busy, textout = 0 and finished = 0 immediately. This includes reset mid-permutation.
REQ-026 While reset is low, start is ignored; the first command accepted after release is honoured normally.

Verification
REQ-027 Reset assert -> textout = 0, finished = 0 the same cycle; release, no start -> outputs stay 0.
REQ-028 start, opmode 0x01, key 0x38393a3b3c3d3e3f3031323334353637 -> finished 1 cycle later; textout 0.
REQ-029 Then opmode 0x02, nonce 0x494a4b4c4d4e4f504142434445464748 -> finished exactly 13 cycles later. Repeat start pulses during those cycles produce no extra finished.
REQ-030 Init+nonce+assoc (0x6162...6b6c), then encrypt 0x4d4e4f505152535455565758414243444546474849 4a4b4c -> ciphertext C. Repeat the identical sequence with decrypt of C -> textout equals the plaintext; both match the Xoodyak software model.
REQ-031 Squeeze (0x06) then squeeze with continue (0x26) -> two different 24-byte outputs, each 13 cycles; both match the software model.
REQ-032 Reset driven low at round 6 of an encrypt -> no finished; state zeroed; a new initialize is accepted normally.

Source files
------------

// File: rtl/xoodyak_build.sv
// xoodyak_build: Xoodyak command engine built around the Xoodoo[12]
// permutation, one round per clock.
//
// Ports
//   eph1        clock, all flops rising-edge
//   reset       asynchronous active-low reset
//   start       command strobe, sampled only while idle
//   input_data  352-bit command data, byte k = input_data[351-8k -: 8]
//   opmode      [2:0] operation, [5] continue flag, [4:3] unused
//   textout     192-bit cipher/plain/squeeze output, held between updates
//   finished    one-cycle completion pulse
//
// FSM states
//   state    | meaning
//   ST_IDLE  | waiting for start with a non-zero op
//   ST_PREP  | command captured; finish single-cycle ops or inject Up constant
//   ST_ROUND | running permutation rounds 0..11, Down applied on round 11
module xoodyak_build (
    input  logic         eph1,
    input  logic         reset,
    input  logic         start,
    input  logic [351:0] input_data,
    input  logic [5:0]   opmode,
    output logic [191:0] textout,
    output logic         finished
);

    typedef enum logic [1:0] {ST_IDLE, ST_PREP, ST_ROUND} state_t;

    localparam logic [2:0] OP_IDLE  = 3'd0;
    localparam logic [2:0] OP_INIT  = 3'd1;
    localparam logic [2:0] OP_NONCE = 3'd2;
    localparam logic [2:0] OP_ASSOC = 3'd3;
    localparam logic [2:0] OP_ENC   = 3'd4;
    localparam logic [2:0] OP_DEC   = 3'd5;
    localparam logic [2:0] OP_SQZ   = 3'd6;
    localparam logic [2:0] OP_RAT   = 3'd7;

    state_t         state, state_nxt;
    logic [383:0]   s, s_nxt;
    logic           phase_down, phase_down_nxt;
    logic [3:0]     rnd, rnd_nxt;
    logic [191:0]   textout_nxt;
    logic           finished_nxt;
    logic           capture;
    logic [2:0]     op_q;
    logic           cont_q;
    logic [351:0]   data_q;

    logic [383:0]   s_round;
    logic [191:0]   y;
    logic [191:0]   xy;
    logic [383:0]   absorb_mask;
    logic [7:0]     cu;
    logic [1:0]     unused_opmode;

    assign unused_opmode = opmode[4:3];

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] round_const(input logic [3:0] r);
        logic [31:0] c;
        case (r)
            4'd0:    c = 32'h058;
            4'd1:    c = 32'h038;
            4'd2:    c = 32'h3C0;
            4'd3:    c = 32'h0D0;
            4'd4:    c = 32'h120;
            4'd5:    c = 32'h014;
            4'd6:    c = 32'h060;
            4'd7:    c = 32'h02C;
            4'd8:    c = 32'h380;
            4'd9:    c = 32'h0F0;
            4'd10:   c = 32'h1A0;
            4'd11:   c = 32'h012;
            default: c = 32'h000;
        endcase
        return c;
    endfunction

    // Lane (y,x) holds state bytes 16y+4x .. 16y+4x+3, least significant first.
    function automatic logic [383:0] xoodoo_round(input logic [383:0] s_in,
                                                  input logic [31:0]  rc);
        logic [31:0]  a [3][4];
        logic [31:0]  b [3][4];
        logic [31:0]  p [4];
        logic [31:0]  e [4];
        logic [31:0]  t [4];
        logic [383:0] s_out;
        for (int yy = 0; yy < 3; yy++)
            for (int x = 0; x < 4; x++)
                for (int k = 0; k < 4; k++)
                    a[yy][x][8*k +: 8] = s_in[383 - 8*(16*yy + 4*x + k) -: 8];
        for (int x = 0; x < 4; x++)
            p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        for (int x = 0; x < 4; x++)
            e[x] = rotl(p[(x + 3) % 4], 5) ^ rotl(p[(x + 3) % 4], 14);
        for (int yy = 0; yy < 3; yy++)
            for (int x = 0; x < 4; x++)
                a[yy][x] = a[yy][x] ^ e[x];
        for (int x = 0; x < 4; x++)
            t[x] = a[1][x];
        for (int x = 0; x < 4; x++) begin
            a[1][x] = t[(x + 3) % 4];
            a[2][x] = rotl(a[2][x], 11);
        end
        a[0][0] = a[0][0] ^ rc;
        for (int yy = 0; yy < 3; yy++)
            for (int x = 0; x < 4; x++)
                b[yy][x] = ~a[(yy + 1) % 3][x] & a[(yy + 2) % 3][x];
        for (int yy = 0; yy < 3; yy++)
            for (int x = 0; x < 4; x++)
                a[yy][x] = a[yy][x] ^ b[yy][x];
        for (int x = 0; x < 4; x++) begin
            a[1][x] = rotl(a[1][x], 1);
            t[x]    = a[2][x];
        end
        for (int x = 0; x < 4; x++)
            a[2][x] = rotl(t[(x + 2) % 4], 8);
        for (int yy = 0; yy < 3; yy++)
            for (int x = 0; x < 4; x++)
                for (int k = 0; k < 4; k++)
                    s_out[383 - 8*(16*yy + 4*x + k) -: 8] = a[yy][x][8*k +: 8];
        return s_out;
    endfunction

    // XOR pattern for Down: first n bytes of x, 0x01 padding at byte n,
    // colour constant cd in the last byte.
    function automatic logic [383:0] down_mask(input logic [383:0] x,
                                               input int           n,
                                               input logic [7:0]   cd);
        logic [383:0] m;
        m = '0;
        for (int k = 0; k < 48; k++)
            if (k < n)
                m[383 - 8*k -: 8] = x[383 - 8*k -: 8];
        m[383 - 8*n -: 8] = m[383 - 8*n -: 8] ^ 8'h01;
        m[7:0] = m[7:0] ^ cd;
        return m;
    endfunction

    assign s_round = xoodoo_round(s, round_const(rnd));
    assign y       = s_round[383:192];
    assign xy      = data_q[351:160] ^ y;

    assign absorb_mask = (op_q == OP_NONCE)
                       ? down_mask({data_q[351:224], 256'b0}, 16, 8'h03)
                       : down_mask({data_q, 32'b0}, 44, cont_q ? 8'h00 : 8'h03);

    always_comb begin
        cu = 8'h00;
        case (op_q)
            OP_ENC, OP_DEC: cu = cont_q ? 8'h00 : 8'h80;
            OP_SQZ:         cu = cont_q ? 8'h00 : 8'h40;
            OP_RAT:         cu = 8'h10;
            default:        cu = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        s_nxt          = s;
        phase_down_nxt = phase_down;
        rnd_nxt        = rnd;
        textout_nxt    = textout;
        finished_nxt   = 1'b0;
        capture        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && (opmode[2:0] != OP_IDLE)) begin
                    capture   = 1'b1;
                    state_nxt = ST_PREP;
                end
            end
            ST_PREP: begin
                if (op_q == OP_INIT) begin
                    s_nxt          = down_mask({data_q[351:224], 256'b0}, 17, 8'h02);
                    phase_down_nxt = 1'b1;
                    finished_nxt   = 1'b1;
                    state_nxt      = ST_IDLE;
                end else if (((op_q == OP_NONCE) || (op_q == OP_ASSOC)) && !phase_down) begin
                    // Absorb directly after an Up: no permutation needed.
                    s_nxt          = s ^ absorb_mask;
                    phase_down_nxt = 1'b1;
                    finished_nxt   = 1'b1;
                    state_nxt      = ST_IDLE;
                end else begin
                    s_nxt     = {s[383:8], s[7:0] ^ cu};
                    rnd_nxt   = 4'd0;
                    state_nxt = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (rnd != 4'd11) begin
                    s_nxt   = s_round;
                    rnd_nxt = rnd + 4'd1;
                end else begin
                    case (op_q)
                        OP_NONCE, OP_ASSOC: s_nxt = s_round ^ absorb_mask;
                        OP_ENC: begin
                            textout_nxt = xy;
                            s_nxt = s_round ^ down_mask({data_q[351:160], 192'b0}, 24, 8'h00);
                        end
                        OP_DEC: begin
                            textout_nxt = xy;
                            s_nxt = s_round ^ down_mask({xy, 192'b0}, 24, 8'h00);
                        end
                        OP_SQZ: begin
                            textout_nxt = y;
                            s_nxt = s_round ^ down_mask('0, 0, 8'h00);
                        end
                        OP_RAT: s_nxt = s_round ^ down_mask({y[191:64], 256'b0}, 16, 8'h00);
                        default: s_nxt = s_round;
                    endcase
                    rnd_nxt        = 4'd0;
                    phase_down_nxt = 1'b1;
                    finished_nxt   = 1'b1;
                    state_nxt      = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            s          <= '0;
            phase_down <= 1'b0;
            rnd        <= 4'd0;
            textout    <= '0;
            finished   <= 1'b0;
            op_q       <= OP_IDLE;
            cont_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            s          <= s_nxt;
            phase_down <= phase_down_nxt;
            rnd        <= rnd_nxt;
            textout    <= textout_nxt;
            finished   <= finished_nxt;
            if (capture) begin
                op_q   <= opmode[2:0];
                cont_q <= opmode[5];
                data_q <= input_data;
            end
        end
    end

endmodule

// File: tb/tb_xoodyak_build.sv
// tb_xoodyak_build: directed bench for xoodyak_build. Latencies, reset
// behaviour and the decrypt round-trip are checked against fixed values;
// cipher/squeeze outputs against a byte-array Xoodyak model kept here.
module tb_xoodyak_build;

    localparam int TMO = 40;
    localparam logic [127:0] KEY   = 128'h38393a3b3c3d3e3f3031323334353637;
    localparam logic [127:0] NONCE = 128'h494a4b4c4d4e4f504142434445464748;
    localparam logic [95:0]  AD    = 96'h6162636465666768696a6b6c;
    localparam logic [191:0] PT    = 192'h4d4e4f5051525354555657584142434445464748494a4b4c;
    localparam logic [191:0] PT2   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [31:0]  RC [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                         32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

    logic         eph1;
    logic         reset;
    logic         start;
    logic [351:0] input_data;
    logic [5:0]   opmode;
    logic [191:0] textout;
    logic         finished;

    int n_chk;
    int n_err;
    int fin_cnt;

    logic [7:0]   m_s [48];
    logic [7:0]   m_x [48];
    bit           m_up_phase;
    logic [191:0] m_txt;
    logic [191:0] m_y;

    logic [191:0] ct;
    logic [191:0] sq1;
    logic [191:0] sq2;
    int           f0;

    xoodyak_build dut (
        .eph1       (eph1),
        .reset      (reset),
        .start      (start),
        .input_data (input_data),
        .opmode     (opmode),
        .textout    (textout),
        .finished   (finished)
    );

    initial begin
        eph1 = 1'b0;
        forever #5 eph1 = ~eph1;
    end

    always @(posedge eph1) if (finished === 1'b1) fin_cnt++;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [7:0] dbyte(input logic [351:0] d, input int k);
        return d[351 - 8*k -: 8];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 48; k++) m_s[k] = 8'h00;
        m_up_phase = 1'b1;
        m_txt = '0;
    endtask

    task automatic m_perm();
        logic [31:0] a [12];
        logic [31:0] b [12];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [31:0] t [4];
        for (int j = 0; j < 12; j++)
            a[j] = {m_s[4*j+3], m_s[4*j+2], m_s[4*j+1], m_s[4*j]};
        for (int r = 0; r < 12; r++) begin
            for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[x+4] ^ a[x+8];
            for (int x = 0; x < 4; x++) e[x] = rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
            for (int j = 0; j < 12; j++) a[j] = a[j] ^ e[j%4];
            for (int x = 0; x < 4; x++) t[x] = a[4+x];
            for (int x = 0; x < 4; x++) begin
                a[4+x] = t[(x+3)%4];
                a[8+x] = rol(a[8+x], 11);
            end
            a[0] = a[0] ^ RC[r];
            for (int j = 0; j < 12; j++) b[j] = ~a[(j+4)%12] & a[(j+8)%12];
            for (int j = 0; j < 12; j++) a[j] = a[j] ^ b[j];
            for (int x = 0; x < 4; x++) begin
                a[4+x] = rol(a[4+x], 1);
                t[x]   = a[8+x];
            end
            for (int x = 0; x < 4; x++) a[8+x] = rol(t[(x+2)%4], 8);
        end
        for (int j = 0; j < 12; j++)
            for (int k = 0; k < 4; k++)
                m_s[4*j+k] = a[j][8*k +: 8];
    endtask

    task automatic m_up(input logic [7:0] cu);
        m_s[47] = m_s[47] ^ cu;
        m_perm();
        for (int k = 0; k < 24; k++) m_y[191 - 8*k -: 8] = m_s[k];
        m_up_phase = 1'b1;
    endtask

    task automatic m_down(input int n, input logic [7:0] cd);
        for (int k = 0; k < n; k++) m_s[k] = m_s[k] ^ m_x[k];
        m_s[n]  = m_s[n] ^ 8'h01;
        m_s[47] = m_s[47] ^ cd;
        m_up_phase = 1'b0;
    endtask

    task automatic m_cmd(input logic [5:0] op, input logic [351:0] d, output int lat);
        logic [7:0] yb;
        lat = 13;
        case (op[2:0])
            3'd0: lat = TMO;
            3'd1: begin
                for (int k = 0; k < 48; k++) m_s[k] = 8'h00;
                for (int k = 0; k < 16; k++) m_x[k] = dbyte(d, k);
                m_x[16] = 8'h00;
                m_down(17, 8'h02);
                lat = 1;
            end
            3'd2: begin
                lat = 1;
                if (!m_up_phase) begin m_up(8'h00); lat = 13; end
                for (int k = 0; k < 16; k++) m_x[k] = dbyte(d, k);
                m_down(16, 8'h03);
            end
            3'd3: begin
                lat = 1;
                if (!m_up_phase) begin m_up(8'h00); lat = 13; end
                for (int k = 0; k < 44; k++) m_x[k] = dbyte(d, k);
                m_down(44, op[5] ? 8'h00 : 8'h03);
            end
            3'd4, 3'd5: begin
                m_up(op[5] ? 8'h00 : 8'h80);
                for (int k = 0; k < 24; k++) begin
                    yb = m_y[191 - 8*k -: 8];
                    m_txt[191 - 8*k -: 8] = dbyte(d, k) ^ yb;
                    m_x[k] = (op[2:0] == 3'd4) ? dbyte(d, k) : (dbyte(d, k) ^ yb);
                end
                m_down(24, 8'h00);
            end
            3'd6: begin
                m_up(op[5] ? 8'h00 : 8'h40);
                m_txt = m_y;
                m_down(0, 8'h00);
            end
            default: begin
                m_up(8'h10);
                for (int k = 0; k < 16; k++) m_x[k] = m_y[191 - 8*k -: 8];
                m_down(16, 8'h00);
            end
        endcase
    endtask

    // Issues one command, optionally hammering start with a different
    // opmode/data while busy, and checks latency, output and pulse count.
    task automatic run_cmd(input string tag, input logic [5:0] op,
                           input logic [351:0] d, input bit spam);
        int exp_lat;
        int cyc;
        int fbase;
        m_cmd(op, d, exp_lat);
        @(negedge eph1);
        opmode = op; input_data = d; start = 1'b1;
        fbase = fin_cnt;
        @(negedge eph1);
        start = 1'b0;
        if (spam) begin opmode = 6'h06; input_data = '1; end
        cyc = 0;
        while ((finished !== 1'b1) && (cyc < TMO)) begin
            if (spam) start = ~start;
            @(negedge eph1);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 192'(cyc), 192'(exp_lat));
        chk({tag, "_text"}, textout, m_txt);
        @(negedge eph1);
        chk({tag, "_pulse"}, {191'b0, finished}, 192'b0);
        @(negedge eph1);
        chk({tag, "_count"}, 192'(fin_cnt - fbase), (op[2:0] == 3'd0) ? 192'd0 : 192'd1);
    endtask

    initial begin
        n_chk = 0; n_err = 0; fin_cnt = 0;
        reset = 1'b1; start = 1'b0; opmode = '0; input_data = '0;
        m_reset();
        #7 reset = 1'b0;
        #1;
        chk("rst_text", textout, 192'b0);
        chk("rst_fin", {191'b0, finished}, 192'b0);
        repeat (2) @(negedge eph1);
        reset = 1'b1;
        repeat (5) @(negedge eph1);
        chk("idle_text", textout, 192'b0);
        chk("idle_fin", 192'(fin_cnt), 192'd0);

        run_cmd("op0", 6'h00, '0, 1'b0);
        run_cmd("init", 6'h01, {KEY, 224'b0}, 1'b0);
        run_cmd("nonce", 6'h02, {NONCE, 224'b0}, 1'b1);
        run_cmd("assoc", 6'h03, {AD, 256'b0}, 1'b0);
        run_cmd("enc", 6'h04, {PT, 160'b0}, 1'b0);
        ct = m_txt;
        run_cmd("enc_cont", 6'h24, {PT2, 160'b0}, 1'b0);

        run_cmd("init2", 6'h01, {KEY, 224'b0}, 1'b0);
        run_cmd("nonce2", 6'h02, {NONCE, 224'b0}, 1'b0);
        run_cmd("assoc2", 6'h03, {AD, 256'b0}, 1'b0);
        run_cmd("dec", 6'h05, {ct, 160'b0}, 1'b0);
        chk("dec_plain", textout, PT);

        run_cmd("sqz", 6'h06, '0, 1'b0);
        sq1 = textout;
        run_cmd("sqz_cont", 6'h26, '0, 1'b0);
        sq2 = textout;
        chk("sqz_differ", {191'b0, sq1 != sq2}, 192'd1);
        run_cmd("ratchet", 6'h07, '0, 1'b0);
        run_cmd("assoc_cont", 6'h23, {PT2, PT, 96'h0}, 1'b0);
        run_cmd("sqz3", 6'h06, '0, 1'b0);

        // Reset in the middle of an encrypt permutation.
        @(negedge eph1);
        opmode = 6'h04; input_data = {PT, 160'b0}; start = 1'b1;
        @(negedge eph1);
        start = 1'b0;
        f0 = fin_cnt;
        repeat (7) @(negedge eph1);
        #2 reset = 1'b0;
        m_reset();
        #1;
        chk("midrst_text", textout, 192'b0);
        chk("midrst_fin", {191'b0, finished}, 192'b0);
        start = 1'b1; opmode = 6'h01; input_data = {KEY, 224'b0};
        repeat (3) @(negedge eph1);
        start = 1'b0;
        reset = 1'b1;
        repeat (20) @(negedge eph1);
        chk("midrst_nofin", 192'(fin_cnt - f0), 192'd0);
        chk("midrst_hold", textout, 192'b0);
        run_cmd("post_nonce", 6'h02, {NONCE, 224'b0}, 1'b0);
        run_cmd("post_sqz", 6'h06, '0, 1'b0);
        run_cmd("post_init", 6'h01, {KEY, 224'b0}, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
